lpif_txrx_gearbox_slave: RTL and testbench
==========================================

Name: lpif_txrx_gearbox_slave

Overview:
- Parametrised successor to the fixed two-slice LPIF slave packer.
- Sits between the single-slice LPIF adapter interface (ustrm_*/dstrm_*) and the logic-link TX/RX FIFOs.
- TX: accumulates LANES LPIF beats into one FIFO word. RX: splits each FIFO word back into LANES beats.
- Adds valid/ready handshakes, FIFO push/pop control, a gen1 half-lane mode and partial-word flush.

Parameters:
LANES, 2, slices per FIFO word; power of two, 2..8
STATE_W, 4, state field bits per slice
PROTID_W, 2, protid field bits per slice
DATA_W, 128, data field bits per slice
CRC_W, 8, crc field bits per slice
SLICE_W (derived), STATE_W+PROTID_W+DATA_W+CRC_W+3 = 145, packed slice width
FIFO_W (derived), LANES*SLICE_W = 290, FIFO word width

Ports:
clk  in  1  single clock for both paths
rst  in  1  asynchronous, active-high reset
m_gen2_mode  in  1  1 = LANES slices per word; 0 = LANES/2 slices per word
ustrm_vld  in  1  TX beat present
ustrm_rdy  out  1  TX beat accepted when vld&rdy
ustrm_state/protid/data/crc  in  STATE_W/PROTID_W/DATA_W/CRC_W  TX slice fields
ustrm_dvalid/crc_valid/valid  in  1 each  TX slice flag fields
tx_flush  in  1  push current partial TX word
txfifo_upstream_data  out  FIFO_W  packed TX word
txfifo_upstream_push  out  1  write strobe
txfifo_upstream_full  in  1  TX FIFO full
rxfifo_downstream_data  in  FIFO_W  RX word; show-ahead, valid while !empty
rxfifo_downstream_empty  in  1  RX FIFO empty
rxfifo_downstream_pop  out  1  RX word consumed
dstrm_vld  out  1  RX beat present
dstrm_rdy  in  1  RX beat taken when vld&rdy
dstrm_state/protid/data/crc/dvalid/crc_valid/valid  out  as ustrm  RX slice fields

Behaviour:
- Slice layout, LSB first: state, protid, data, dvalid, crc, crc_valid, valid. Slice k occupies word bits [k*SLICE_W +: SLICE_W].
- NL (active lanes) = LANES if m_gen2_mode, else LANES/2.
- m_gen2_mode is sampled into a mode register only when both paths are at slot 0 with no held word. A change at any other time is ignored until that point.
- Reset values: ustrm_rdy=0 during reset, then 1; txfifo_upstream_push=0; txfifo_upstream_data=0; rxfifo_downstream_pop=0; dstrm_vld=0; all dstrm_* fields=0; slot counters=0; mode register=1.

TX path:
- Accumulator, slot counter tx_idx, and one output word register with flag out_v.
- ustrm_rdy = !(out_v & txfifo_upstream_full).
- On an accepted beat: slice written to slot tx_idx.
  - If tx_idx==NL-1: accumulator plus this slice moves to the output register, out_v=1, tx_idx=0.
  - Otherwise tx_idx increments.
- Slots >= NL are always zero.
- txfifo_upstream_push = out_v & !txfifo_upstream_full (combinational from registers); the push clears out_v.
- Push and reload in the same cycle are legal: out_v stays 1 with the new word. Throughput is one beat per cycle.
- tx_flush with tx_idx!=0 and no accepted beat: the partial word moves to the output register with unfilled slots zero (their valid=0), tx_idx=0.
- tx_flush with tx_idx==0: no-op.
- tx_flush coincident with an accepted beat: the beat is included first, then the word is flushed.
- Latency: last beat accepted in cycle N -> push in cycle N+1 if not full.

RX path:
- Holding word register with flag hold_v, and slot counter rx_idx.
- When hold_v==0 and empty==0: rxfifo_downstream_pop=1 for one cycle, word loaded, hold_v=1, rx_idx=0.
- dstrm_vld = hold_v. dstrm_* fields are slice rx_idx of the held word; they are held stable while vld & !rdy.
- On a handshake: rx_idx increments.
  - At rx_idx==NL-1 the word is released. If the FIFO is not empty, the next word pops in the same cycle (no bubble).
- Latency: word visible in cycle N -> first beat valid in cycle N+1.
- An all-zero slice is still emitted; filtering is left to the adapter.
- Reset mid-word: partial TX accumulation and the held RX word are discarded. No push or pop occurs while rst=1.

Decomposition:
- Package lpif_gearbox_pkg: slice field widths, offsets and SLICE_W function, a packed slice_t struct, and pack/unpack functions.
- One sub-module lpif_gearbox_rx_unpack holds the RX holding register and slice counter. The TX path stays in the top module.

Test Plan:
- LANES=2, gen2, 4 back-to-back beats (data 0x11.., 0x22.., 0x33.., 0x44..) with full=0 -> 2 pushes; word0 slice0 data=0x11.., slice1 data=0x22..; ustrm_rdy stays 1.
- out_v=1, hold full=1 for 5 cycles, keep offering beats -> ustrm_rdy=0 after the next word completes; no push; word released unchanged after full drops.
- LANES=4, gen1 (NL=2), 2 beats -> one push with slots 2..3 all zero; mode change requested mid-word takes effect only after the word.
- 1 beat, then tx_flush -> push with slot0 populated and slot1 zero; tx_flush with tx_idx=0 -> no push.
- RX: 3 words queued, dstrm_rdy always 1 -> 6 consecutive beats, 3 pops, no bubble between words; dstrm_rdy toggled -> fields stable while stalled.
- Assert rst between beats of a word -> all outputs are at reset values immediately; after release, the first push contains only post-reset beats.

Source files
------------

// File: rtl/lpif_gearbox_pkg.sv
// Shared slice geometry for the LPIF gearbox: field widths, bit offsets,
// the packed slice record and pack/unpack helpers.
package lpif_gearbox_pkg;

    localparam int STATE_W_D  = 4;
    localparam int PROTID_W_D = 2;
    localparam int DATA_W_D   = 128;
    localparam int CRC_W_D    = 8;

    function automatic int slice_w(input int s, input int p, input int d, input int c);
        return s + p + d + c + 3;
    endfunction

    localparam int SLICE_W_D = slice_w(STATE_W_D, PROTID_W_D, DATA_W_D, CRC_W_D);

    // Bit offsets inside one slice, LSB first
    localparam int OFF_STATE     = 0;
    localparam int OFF_PROTID    = OFF_STATE + STATE_W_D;
    localparam int OFF_DATA      = OFF_PROTID + PROTID_W_D;
    localparam int OFF_DVALID    = OFF_DATA + DATA_W_D;
    localparam int OFF_CRC       = OFF_DVALID + 1;
    localparam int OFF_CRC_VALID = OFF_CRC + CRC_W_D;
    localparam int OFF_VALID     = OFF_CRC_VALID + 1;

    typedef struct packed {
        logic                  valid;
        logic                  crc_valid;
        logic [CRC_W_D-1:0]    crc;
        logic                  dvalid;
        logic [DATA_W_D-1:0]   data;
        logic [PROTID_W_D-1:0] protid;
        logic [STATE_W_D-1:0]  state;
    } slice_t;

    function automatic logic [SLICE_W_D-1:0] pack_slice(input slice_t s);
        return s;
    endfunction

    function automatic slice_t unpack_slice(input logic [SLICE_W_D-1:0] v);
        return slice_t'(v);
    endfunction

endpackage

// File: rtl/lpif_gearbox_rx_unpack.sv
// RX side: holds one FIFO word and walks its active slices out one beat
// at a time, popping the next word in the same cycle the last beat goes.
module lpif_gearbox_rx_unpack #(
    parameter int LANES   = 2,
    parameter int SLICE_W = 145,
    parameter int FIFO_W  = LANES * SLICE_W,
    parameter int IDX_W   = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IDX_W-1:0]   last_idx,
    input  logic [FIFO_W-1:0]  fifo_data,
    input  logic               fifo_empty,
    output logic               fifo_pop,
    input  logic               beat_rdy,
    output logic               beat_vld,
    output logic [SLICE_W-1:0] beat_slice,
    output logic               busy
);

    logic [FIFO_W-1:0]  hold_reg;
    logic               hold_v_reg;
    logic [IDX_W-1:0]   rx_idx_reg;
    logic [SLICE_W-1:0] slices [LANES];
    logic               handshake;
    logic               release_word;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_slice
            assign slices[gi] = hold_reg[gi*SLICE_W +: SLICE_W];
        end
    endgenerate

    assign handshake    = hold_v_reg & beat_rdy;
    assign release_word = handshake & (rx_idx_reg == last_idx);
    // Refill either into an empty holder or back-to-back behind the last beat
    assign fifo_pop     = !rst & !fifo_empty & (!hold_v_reg | release_word);
    assign beat_vld     = hold_v_reg;
    assign beat_slice   = slices[rx_idx_reg];
    assign busy         = hold_v_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_reg   <= '0;
            hold_v_reg <= 1'b0;
            rx_idx_reg <= '0;
        end else if (fifo_pop) begin
            hold_reg   <= fifo_data;
            hold_v_reg <= 1'b1;
            rx_idx_reg <= '0;
        end else if (release_word) begin
            hold_v_reg <= 1'b0;
            rx_idx_reg <= '0;
        end else if (handshake) begin
            rx_idx_reg <= rx_idx_reg + 1'b1;
        end
    end

endmodule

// File: rtl/lpif_txrx_gearbox_slave.sv
// LPIF slave gearbox: packs LPIF beats into FIFO words on TX and splits
// FIFO words back into beats on RX, with gen1 half-lane mode and flush.
module lpif_txrx_gearbox_slave
    import lpif_gearbox_pkg::*;
#(
    parameter int LANES    = 2,
    parameter int STATE_W  = 4,
    parameter int PROTID_W = 2,
    parameter int DATA_W   = 128,
    parameter int CRC_W    = 8,
    parameter int SLICE_W  = slice_w(STATE_W, PROTID_W, DATA_W, CRC_W),
    parameter int FIFO_W   = LANES * SLICE_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m_gen2_mode,
    input  logic                ustrm_vld,
    output logic                ustrm_rdy,
    input  logic [STATE_W-1:0]  ustrm_state,
    input  logic [PROTID_W-1:0] ustrm_protid,
    input  logic [DATA_W-1:0]   ustrm_data,
    input  logic [CRC_W-1:0]    ustrm_crc,
    input  logic                ustrm_dvalid,
    input  logic                ustrm_crc_valid,
    input  logic                ustrm_valid,
    input  logic                tx_flush,
    output logic [FIFO_W-1:0]   txfifo_upstream_data,
    output logic                txfifo_upstream_push,
    input  logic                txfifo_upstream_full,
    input  logic [FIFO_W-1:0]   rxfifo_downstream_data,
    input  logic                rxfifo_downstream_empty,
    output logic                rxfifo_downstream_pop,
    output logic                dstrm_vld,
    input  logic                dstrm_rdy,
    output logic [STATE_W-1:0]  dstrm_state,
    output logic [PROTID_W-1:0] dstrm_protid,
    output logic [DATA_W-1:0]   dstrm_data,
    output logic [CRC_W-1:0]    dstrm_crc,
    output logic                dstrm_dvalid,
    output logic                dstrm_crc_valid,
    output logic                dstrm_valid
);

    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic               mode_reg;
    logic [IDX_W-1:0]   last_idx;
    logic [IDX_W-1:0]   tx_idx_reg;
    logic [FIFO_W-1:0]  acc_reg;
    logic [FIFO_W-1:0]  acc_next;
    logic [FIFO_W-1:0]  out_reg;
    logic               out_v_reg;
    logic [SLICE_W-1:0] ustrm_slice;
    logic [SLICE_W-1:0] rx_slice;
    logic               tx_accept;
    logic               tx_complete;
    logic               rx_busy;
    logic               mode_en;

    assign last_idx    = mode_reg ? IDX_W'(LANES - 1) : IDX_W'(LANES / 2 - 1);
    assign ustrm_slice = {ustrm_valid, ustrm_crc_valid, ustrm_crc, ustrm_dvalid,
                          ustrm_data, ustrm_protid, ustrm_state};

    assign ustrm_rdy            = !rst & !(out_v_reg & txfifo_upstream_full);
    assign tx_accept            = ustrm_vld & ustrm_rdy;
    assign txfifo_upstream_push = out_v_reg & !txfifo_upstream_full;
    assign txfifo_upstream_data = out_reg;

    // A flush folds in a coincident beat; an empty accumulator flushes nothing
    assign tx_complete = ustrm_rdy &
                         ((tx_accept & (tx_idx_reg == last_idx)) |
                          (tx_flush & (tx_accept | (tx_idx_reg != '0))));

    // Mode may only move when neither path is partway through a word
    assign mode_en = (tx_idx_reg == '0) & !out_v_reg & !tx_accept & !rx_busy;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_acc
            assign acc_next[gi*SLICE_W +: SLICE_W] =
                (tx_accept && tx_idx_reg == IDX_W'(gi)) ? ustrm_slice
                                                        : acc_reg[gi*SLICE_W +: SLICE_W];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_reg   <= 1'b1;
            tx_idx_reg <= '0;
            acc_reg    <= '0;
            out_reg    <= '0;
            out_v_reg  <= 1'b0;
        end else begin
            if (tx_complete) begin
                out_reg    <= acc_next;
                out_v_reg  <= 1'b1;
                acc_reg    <= '0;
                tx_idx_reg <= '0;
            end else begin
                if (txfifo_upstream_push)
                    out_v_reg <= 1'b0;
                if (tx_accept) begin
                    acc_reg    <= acc_next;
                    tx_idx_reg <= tx_idx_reg + 1'b1;
                end
            end
            if (mode_en)
                mode_reg <= m_gen2_mode;
        end
    end

    lpif_gearbox_rx_unpack #(
        .LANES   (LANES),
        .SLICE_W (SLICE_W),
        .FIFO_W  (FIFO_W),
        .IDX_W   (IDX_W)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .last_idx   (last_idx),
        .fifo_data  (rxfifo_downstream_data),
        .fifo_empty (rxfifo_downstream_empty),
        .fifo_pop   (rxfifo_downstream_pop),
        .beat_rdy   (dstrm_rdy),
        .beat_vld   (dstrm_vld),
        .beat_slice (rx_slice),
        .busy       (rx_busy)
    );

    assign {dstrm_valid, dstrm_crc_valid, dstrm_crc, dstrm_dvalid,
            dstrm_data, dstrm_protid, dstrm_state} = rx_slice;

endmodule

// File: tb/tb_lpif_txrx_gearbox_slave.sv
// Directed bench for the LPIF gearbox: scoreboards for TX words and RX beats,
// a LANES=2 instance for the main paths and a LANES=4 instance for gen1 mode.
module tb_lpif_txrx_gearbox_slave;
    import lpif_gearbox_pkg::*;

    localparam int SW = 145;
    localparam int W2 = 2 * SW;
    localparam int W4 = 4 * SW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic         mode2 = 1'b1, mode4 = 1'b0;
    logic         vld2 = 1'b0, vld4 = 1'b0;
    logic         flush2 = 1'b0, flush4 = 1'b0;
    logic [3:0]   f_state = '0;
    logic [1:0]   f_protid = '0;
    logic [127:0] f_data = '0;
    logic [7:0]   f_crc = '0;
    logic         f_dvalid = 1'b0, f_crc_valid = 1'b0, f_valid = 1'b0;
    logic         full = 1'b0;
    logic         rdy2, rdy4, push2, push4, pop2, pop4;
    logic [W2-1:0] txd2;
    logic [W4-1:0] txd4;
    logic [W2-1:0] rx_data = '0;
    logic          rx_empty = 1'b1;
    logic          dstrm_rdy = 1'b1;
    logic          dv;
    logic [3:0]    d_state;
    logic [1:0]    d_protid;
    logic [127:0]  d_data;
    logic [7:0]    d_crc;
    logic          d_dvalid, d_crc_valid, d_valid;
    logic [SW-1:0] rx_fields;
    logic          u4_vld, u4_dvalid, u4_crc_valid, u4_valid;
    logic [3:0]    u4_state;
    logic [1:0]    u4_protid;
    logic [127:0]  u4_data;
    logic [7:0]    u4_crc;

    assign rx_fields = {d_valid, d_crc_valid, d_crc, d_dvalid, d_data, d_protid, d_state};

    lpif_txrx_gearbox_slave #(.LANES(2)) u_dut (
        .clk(clk), .rst(rst), .m_gen2_mode(mode2),
        .ustrm_vld(vld2), .ustrm_rdy(rdy2),
        .ustrm_state(f_state), .ustrm_protid(f_protid), .ustrm_data(f_data), .ustrm_crc(f_crc),
        .ustrm_dvalid(f_dvalid), .ustrm_crc_valid(f_crc_valid), .ustrm_valid(f_valid),
        .tx_flush(flush2),
        .txfifo_upstream_data(txd2), .txfifo_upstream_push(push2), .txfifo_upstream_full(full),
        .rxfifo_downstream_data(rx_data), .rxfifo_downstream_empty(rx_empty),
        .rxfifo_downstream_pop(pop2),
        .dstrm_vld(dv), .dstrm_rdy(dstrm_rdy),
        .dstrm_state(d_state), .dstrm_protid(d_protid), .dstrm_data(d_data), .dstrm_crc(d_crc),
        .dstrm_dvalid(d_dvalid), .dstrm_crc_valid(d_crc_valid), .dstrm_valid(d_valid)
    );

    lpif_txrx_gearbox_slave #(.LANES(4)) u_dut4 (
        .clk(clk), .rst(rst), .m_gen2_mode(mode4),
        .ustrm_vld(vld4), .ustrm_rdy(rdy4),
        .ustrm_state(f_state), .ustrm_protid(f_protid), .ustrm_data(f_data), .ustrm_crc(f_crc),
        .ustrm_dvalid(f_dvalid), .ustrm_crc_valid(f_crc_valid), .ustrm_valid(f_valid),
        .tx_flush(flush4),
        .txfifo_upstream_data(txd4), .txfifo_upstream_push(push4), .txfifo_upstream_full(1'b0),
        .rxfifo_downstream_data({W4{1'b0}}), .rxfifo_downstream_empty(1'b1),
        .rxfifo_downstream_pop(pop4),
        .dstrm_vld(u4_vld), .dstrm_rdy(1'b0),
        .dstrm_state(u4_state), .dstrm_protid(u4_protid), .dstrm_data(u4_data), .dstrm_crc(u4_crc),
        .dstrm_dvalid(u4_dvalid), .dstrm_crc_valid(u4_crc_valid), .dstrm_valid(u4_valid)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pushes2 = 0, pushes4 = 0, pops = 0, beats = 0, stall_checks = 0;
    logic watch_rdy = 1'b0, rdy_dropped = 1'b0;
    logic pop_armed = 1'b0;
    logic stall_prev = 1'b0;
    logic [SW-1:0] stall_val = '0;
    logic [W2-1:0] tx2_q[$];
    logic [W4-1:0] tx4_q[$];
    logic [SW-1:0] rx_exp[$];
    logic [W2-1:0] rx_fifo[$];
    int beat_cyc[$];

    task automatic check(input string tag, input logic [W4-1:0] obs, input logic [W4-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [SW-1:0] mk(input logic [7:0] b);
        slice_t s;
        s.state     = b[3:0];
        s.protid    = b[5:4];
        s.data      = {16{b}};
        s.dvalid    = b[0];
        s.crc       = ~b;
        s.crc_valid = b[1];
        s.valid     = 1'b1;
        return pack_slice(s);
    endfunction

    function automatic logic [W2-1:0] w2(input logic [7:0] a, input logic [7:0] b);
        return {mk(b), mk(a)};
    endfunction

    task automatic drive(input logic [7:0] b);
        f_state     = b[3:0];
        f_protid    = b[5:4];
        f_data      = {16{b}};
        f_dvalid    = b[0];
        f_crc       = ~b;
        f_crc_valid = b[1];
        f_valid     = 1'b1;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic refresh_rx();
        rx_empty = (rx_fifo.size() == 0);
        rx_data  = (rx_fifo.size() > 0) ? rx_fifo[0] : '0;
    endtask

    task automatic rx_queue(input logic [7:0] a, input logic [7:0] b);
        rx_fifo.push_back(w2(a, b));
        rx_exp.push_back(mk(a));
        rx_exp.push_back(mk(b));
        refresh_rx();
    endtask

    // Offer one beat and wait (bounded) until it is accepted; vld stays high
    task automatic send(input int which, input logic [7:0] b);
        logic ok;
        int n;
        ok = 1'b0;
        n = 0;
        drive(b);
        if (which == 2) vld2 = 1'b1; else vld4 = 1'b1;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = (which == 2) ? rdy2 : rdy4;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) check("accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic idle();
        vld2 = 1'b0;
        vld4 = 1'b0;
    endtask

    always @(posedge clk) cyc++;

    // Monitors sample on the falling edge; inputs move 1ns after the rising edge
    always @(negedge clk) begin
        pop_armed = pop2;
        if (pop2) pops++;
        if (watch_rdy && vld2 && !rdy2) rdy_dropped = 1'b1;
        if (push2) begin
            pushes2++;
            if (tx2_q.size() > 0) check("tx2_word", txd2, tx2_q.pop_front());
            else check("tx2_unexpected_push", 1'b1, 1'b0);
        end
        if (push4) begin
            pushes4++;
            if (tx4_q.size() > 0) check("tx4_word", txd4, tx4_q.pop_front());
            else check("tx4_unexpected_push", 1'b1, 1'b0);
        end
        if (stall_prev && dv) begin
            stall_checks++;
            check("rx_stall_stable", rx_fields, stall_val);
        end
        if (dv && dstrm_rdy) begin
            beats++;
            beat_cyc.push_back(cyc);
            if (rx_exp.size() > 0) check("rx_slice", rx_fields, rx_exp.pop_front());
            else check("rx_unexpected_beat", 1'b1, 1'b0);
        end
        stall_prev = dv && !dstrm_rdy;
        stall_val  = rx_fields;
    end

    // RX FIFO model: show-ahead head, advanced just after a popping edge
    always @(posedge clk) begin
        if (pop_armed) begin
            #1;
            if (rx_fifo.size() > 0) void'(rx_fifo.pop_front());
            refresh_rx();
        end
    end

    initial begin
        int p;
        int gap;
        rst = 1'b1;
        rx_queue(8'hA1, 8'hA2);
        rx_queue(8'hB1, 8'hB2);
        rx_queue(8'hC1, 8'hC2);
        tick(3);
        check("rst_ustrm_rdy", rdy2, 1'b0);
        check("rst_push", push2, 1'b0);
        check("rst_txdata", txd2, '0);
        check("rst_pop_while_nonempty", pop2, 1'b0);
        check("rst_dstrm_vld", dv, 1'b0);
        check("rst_dstrm_fields", rx_fields, '0);
        rst = 1'b0;
        #1;
        check("ustrm_rdy_after_rst", rdy2, 1'b1);

        // Back-to-back beats, gen2
        watch_rdy = 1'b1;
        tx2_q.push_back(w2(8'h11, 8'h22));
        tx2_q.push_back(w2(8'h33, 8'h44));
        send(2, 8'h11);
        send(2, 8'h22);
        send(2, 8'h33);
        send(2, 8'h44);
        idle();
        tick(4);
        watch_rdy = 1'b0;
        check("t1_pushes", pushes2, 2);
        check("t1_rdy_never_dropped", rdy_dropped, 1'b0);

        // RX streaming of the three words queued during reset
        gap = (beat_cyc.size() >= 6) ? beat_cyc[5] - beat_cyc[0] : -1;
        check("rx_beats", beats, 6);
        check("rx_no_bubble", gap, 5);
        check("rx_pops", pops, 3);

        // Back-pressure from a full TX FIFO
        full = 1'b1;
        tx2_q.push_back(w2(8'h55, 8'h66));
        tx2_q.push_back(w2(8'h77, 8'h88));
        send(2, 8'h55);
        send(2, 8'h66);
        drive(8'h77);
        p = pushes2;
        tick(5);
        @(negedge clk);
        check("full_rdy_low", rdy2, 1'b0);
        check("full_no_push", pushes2, p);
        check("full_word_held", txd2, w2(8'h55, 8'h66));
        @(posedge clk);
        #1;
        full = 1'b0;
        send(2, 8'h77);
        send(2, 8'h88);
        idle();
        tick(3);
        check("full_release_pushes", pushes2, p + 2);

        // Flush of a partial word, of an empty accumulator, and with a beat
        send(2, 8'h99);
        idle();
        tick(2);
        p = pushes2;
        tx2_q.push_back({{SW{1'b0}}, mk(8'h99)});
        flush2 = 1'b1;
        tick(1);
        flush2 = 1'b0;
        tick(2);
        check("flush_partial_push", pushes2, p + 1);
        p = pushes2;
        flush2 = 1'b1;
        tick(1);
        flush2 = 1'b0;
        tick(3);
        check("flush_idle_nop", pushes2, p);
        tx2_q.push_back({{SW{1'b0}}, mk(8'h5A)});
        flush2 = 1'b1;
        send(2, 8'h5A);
        flush2 = 1'b0;
        idle();
        tick(3);
        check("flush_with_beat", pushes2, p + 1);

        // LANES=4 gen1 words, then a mode change requested mid-word
        tx4_q.push_back({{2*SW{1'b0}}, mk(8'h34), mk(8'h12)});
        send(4, 8'h12);
        send(4, 8'h34);
        idle();
        tick(3);
        check("gen1_one_push", pushes4, 1);
        tx4_q.push_back({{2*SW{1'b0}}, mk(8'h78), mk(8'h56)});
        send(4, 8'h56);
        mode4 = 1'b1;
        send(4, 8'h78);
        idle();
        tick(4);
        check("gen1_mode_deferred", pushes4, 2);
        tx4_q.push_back({mk(8'hF0), mk(8'hDE), mk(8'hBC), mk(8'h9A)});
        send(4, 8'h9A);
        send(4, 8'hBC);
        send(4, 8'hDE);
        send(4, 8'hF0);
        idle();
        tick(3);
        check("gen2_after_switch", pushes4, 3);

        // RX with a stalling consumer
        rx_queue(8'hD1, 8'hD2);
        rx_queue(8'hE1, 8'hE2);
        for (int i = 0; i < 20; i++) begin
            dstrm_rdy = (i % 3 == 2);
            tick(1);
        end
        dstrm_rdy = 1'b1;
        tick(4);
        check("rx_drained", rx_exp.size(), 0);
        check("rx_stalls_seen", stall_checks > 0, 1'b1);
        check("rx_pops_total", pops, 5);

        // Reset in the middle of a TX word
        send(2, 8'hAA);
        idle();
        rst = 1'b1;
        #1;
        check("midrst_ustrm_rdy", rdy2, 1'b0);
        check("midrst_push", push2, 1'b0);
        check("midrst_txdata", txd2, '0);
        check("midrst_dstrm_vld", dv, 1'b0);
        tick(2);
        rst = 1'b0;
        tx2_q.push_back(w2(8'hBB, 8'hCC));
        send(2, 8'hBB);
        send(2, 8'hCC);
        idle();
        tick(3);
        check("tx2_drained", tx2_q.size(), 0);
        check("tx4_drained", tx4_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
